// File: rtl/madam_mem_arbiter.sv
// Shares the MADAM memory port between the CPU and NUM_DMA DMA channels (round-robin DMA, guaranteed CPU slot).
// Latency: request in IDLE -> strobe next cycle -> ack one cycle after mem_ack; one access outstanding.
// Backpressure: requests are held until acked; mem_ack stalls ACCESS (bounded when MEMARB_TIMEOUT_EN is defined).
module madam_mem_arbiter #(
    parameter int NUM_DMA        = 4,
    parameter int CPU_SLOT       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_25m,
    input  logic                 reset_n,
    input  logic                 cpu_stb,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_sel,
    output logic                 cpu_ack,
    output logic [31:0]          cpu_rdata,
    input  logic [NUM_DMA-1:0]   dma_req,
    input  logic [NUM_DMA-1:0]   dma_we,
    input  logic [32*NUM_DMA-1:0] dma_addr,
    input  logic [32*NUM_DMA-1:0] dma_wdata,
    output logic [NUM_DMA-1:0]   dma_ack,
    output logic [31:0]          dma_rdata,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_dout,
    output logic [3:0]           mem_sel,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic [31:0]          mem_din,
    input  logic                 mem_ack,
    output logic [2:0]           grant_id,
    output logic                 timeout_flag
);

    localparam int SW = $clog2(CPU_SLOT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef MEMARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [2:0]  GID_NONE = 3'd7;
    localparam logic [31:0] TMO_DATA = 32'hBAD0_BAD0;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          dout_q, dout_d;
    logic [3:0]           sel_q, sel_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic [NUM_DMA-1:0]   dma_ack_q, dma_ack_d;
    logic [31:0]          cpu_rdata_q, cpu_rdata_d;
    logic [31:0]          dma_rdata_q, dma_rdata_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]        streak_q, streak_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_flag_q, tmo_flag_d;

    logic                 dma_any;
    logic [2:0]           dma_win;
    logic [NUM_DMA-1:0]   req_rot;
    logic [NUM_DMA-1:0]   we_rot;
    logic                 cpu_wins;
    logic                 finish;
    logic [31:0]          fin_data;
    int                   idx;

    // Descending scan so the channel closest to rr_ptr (smallest offset) is the last one written.
    always_comb begin
        dma_any = 1'b0;
        dma_win = '0;
        idx     = 0;
        req_rot = '0;
        for (int k = NUM_DMA - 1; k >= 0; k--) begin
            idx     = (int'(rr_ptr_q) + k) % NUM_DMA;
            req_rot = dma_req >> idx;
            if (req_rot[0]) begin
                dma_any = 1'b1;
                dma_win = 3'(idx);
            end
        end
    end

    assign we_rot   = dma_we >> dma_win;
    assign cpu_wins = cpu_stb && ((streak_q >= SW'(CPU_SLOT)) || !dma_any);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        sel_d       = sel_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = '0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        rr_ptr_d    = rr_ptr_q;
        streak_d    = streak_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_flag_d  = tmo_flag_q;
        finish      = 1'b0;
        fin_data    = mem_din;

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = '0;
                if (!cpu_stb) begin
                    streak_d = '0;
                end
                if (cpu_wins) begin
                    state_d  = S_ACCESS;
                    grant_d  = 3'd0;
                    addr_d   = cpu_addr;
                    dout_d   = cpu_wdata;
                    sel_d    = cpu_sel;
                    rd_d     = !cpu_we;
                    wr_d     = cpu_we;
                    streak_d = '0;
                end else if (dma_any) begin
                    state_d  = S_ACCESS;
                    grant_d  = dma_win + 3'd1;
                    addr_d   = dma_addr[32*dma_win +: 32];
                    dout_d   = dma_wdata[32*dma_win +: 32];
                    sel_d    = 4'hF;
                    rd_d     = !we_rot[0];
                    wr_d     = we_rot[0];
                    rr_ptr_d = (dma_win == 3'(NUM_DMA - 1)) ? 3'd0 : dma_win + 3'd1;
                    if (cpu_stb && (streak_q != SW'(CPU_SLOT))) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end
            S_ACCESS: begin
                // A mem_ack in the timeout cycle wins: the access completes normally.
                if (mem_ack) begin
                    finish = 1'b1;
                end else if (TMO_EN && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    finish     = 1'b1;
                    fin_data   = TMO_DATA;
                    tmo_flag_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
                if (finish) begin
                    state_d = S_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (grant_q == 3'd0) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = fin_data;
                    end else begin
                        dma_ack_d   = NUM_DMA'(1) << (grant_q - 3'd1);
                        dma_rdata_d = fin_data;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = GID_NONE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = GID_NONE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= GID_NONE;
            addr_q      <= '0;
            dout_q      <= '0;
            sel_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            rr_ptr_q    <= '0;
            streak_q    <= '0;
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            rr_ptr_q    <= rr_ptr_d;
            streak_q    <= streak_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_flag_q  <= tmo_flag_d;
        end
    end

    assign cpu_ack      = cpu_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dma_ack      = dma_ack_q;
    assign dma_rdata    = dma_rdata_q;
    assign mem_addr     = addr_q;
    assign mem_dout     = dout_q;
    assign mem_sel      = sel_q;
    assign mem_rd       = rd_q;
    assign mem_wr       = wr_q;
    assign grant_id     = grant_q;
    assign timeout_flag = TMO_EN ? tmo_flag_q : 1'b0;

endmodule

// File: tb/tb_madam_mem_arbiter.sv
// Directed bench for madam_mem_arbiter: cycle-vector table plus reset-abort and timeout sequences.
module tb_madam_mem_arbiter;

    localparam int ND = 4;
    localparam logic [31:0] CPU_ADDR = 32'h0020_0000;
    localparam logic [31:0] CPU_WD   = 32'hA5A5_0001;
    localparam logic [3:0]  CPU_SEL  = 4'b0011;

    logic          clk_25m = 1'b0;
    logic          reset_n;
    logic          cpu_stb, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic [3:0]    cpu_sel;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;
    logic [ND-1:0] dma_req, dma_we, dma_ack;
    logic [32*ND-1:0] dma_addr, dma_wdata;
    logic [31:0]   dma_rdata, mem_addr, mem_dout, mem_din;
    logic [3:0]    mem_sel;
    logic          mem_rd, mem_wr, mem_ack;
    logic [2:0]    grant_id;
    logic          timeout_flag;

    always #20 clk_25m = ~clk_25m;

    madam_mem_arbiter #(.NUM_DMA(ND), .CPU_SLOT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_25m(clk_25m), .reset_n(reset_n),
        .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_sel(cpu_sel), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_sel(mem_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_ack(mem_ack),
        .grant_id(grant_id), .timeout_flag(timeout_flag)
    );

    typedef struct {
        logic        cpu_stb;
        logic        cpu_we;
        logic [3:0]  dma_req;
        logic [3:0]  dma_we;
        logic        mem_ack;
        logic [31:0] mem_din;
        logic        rd, wr, cack;
        logic [3:0]  dack;
        logic [2:0]  gid;
        logic [31:0] addr, dout;
        logic [3:0]  sel;
        logic [31:0] crd, drd;
    } vec_t;

    vec_t vt[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] e_addr = '0, e_dout = '0, e_crd = '0, e_drd = '0;
    logic [3:0]  e_sel = '0;

    function automatic logic [31:0] ch_addr(input int c);
        case (c)
            0: return 32'h0001_0000;
            1: return 32'h0002_0000;
            2: return 32'h0004_0000;
            default: return 32'h0008_0000;
        endcase
    endfunction

    function automatic logic [31:0] ch_wd(input int c);
        case (c)
            0: return 32'hD0D0_0000;
            1: return 32'hD0D0_0001;
            2: return 32'hCAFE_F00D;
            default: return 32'hD0D0_0003;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25m);
        #1;
    endtask

    // One transaction: owner 0 = CPU, c+1 = DMA c; ack arrives after 'waits' extra ACCESS cycles.
    task automatic add_txn(input logic cs, input logic cw, input logic [3:0] rq, input logic [3:0] dw,
                           input int owner, input logic [31:0] din, input int waits);
        vec_t v;
        logic w;
        if (owner == 0) begin
            w = cw; e_addr = CPU_ADDR; e_dout = CPU_WD; e_sel = CPU_SEL;
        end else begin
            w = dw[owner-1]; e_addr = ch_addr(owner-1); e_dout = ch_wd(owner-1); e_sel = 4'hF;
        end
        v.cpu_stb = cs; v.cpu_we = cw; v.dma_req = rq; v.dma_we = dw;
        v.mem_ack = 1'b0; v.mem_din = '0;
        v.rd = !w; v.wr = w; v.cack = 1'b0; v.dack = '0; v.gid = 3'(owner);
        v.addr = e_addr; v.dout = e_dout; v.sel = e_sel; v.crd = e_crd; v.drd = e_drd;
        for (int k = 0; k <= waits; k++) vt.push_back(v);
        v.mem_ack = 1'b1; v.mem_din = din; v.rd = 1'b0; v.wr = 1'b0;
        if (owner == 0) begin
            v.cack = 1'b1; e_crd = din;
        end else begin
            v.dack = 4'(1 << (owner - 1)); e_drd = din;
        end
        v.crd = e_crd; v.drd = e_drd;
        vt.push_back(v);
        v.mem_ack = 1'b0; v.mem_din = '0; v.cack = 1'b0; v.dack = '0; v.gid = 3'd7;
        vt.push_back(v);
    endtask

    task automatic add_idle();
        vec_t v;
        v.cpu_stb = 1'b0; v.cpu_we = 1'b0; v.dma_req = '0; v.dma_we = '0;
        v.mem_ack = 1'b0; v.mem_din = '0;
        v.rd = 1'b0; v.wr = 1'b0; v.cack = 1'b0; v.dack = '0; v.gid = 3'd7;
        v.addr = e_addr; v.dout = e_dout; v.sel = e_sel; v.crd = e_crd; v.drd = e_drd;
        vt.push_back(v);
    endtask

    task automatic cpu_done_check(input string nm, input logic [31:0] rdat, input logic flag);
        chk({nm, ".cack"}, 32'(cpu_ack), 32'd1);
        chk({nm, ".crd"}, cpu_rdata, rdat);
        chk({nm, ".rd"}, 32'(mem_rd), 32'd0);
        chk({nm, ".flag"}, 32'(timeout_flag), 32'(flag));
    endtask

    initial begin
        int rr_own[5];
        int mix_own[6];
        rr_own  = '{1, 2, 3, 4, 1};
        mix_own = '{4, 1, 2, 3, 0, 4};

        // Vector table: CPU read, DMA round-robin, DMA2 write with waits, CPU slot under DMA load.
        add_txn(1'b1, 1'b0, 4'h0, 4'h0, 0, 32'h1234_5678, 0);
        add_idle();
        for (int n = 0; n < 5; n++) add_txn(1'b0, 1'b0, 4'hF, 4'h0, rr_own[n], 32'h1111_0000 + 32'(n), 0);
        add_idle();
        add_txn(1'b0, 1'b0, 4'b0100, 4'b0100, 3, e_drd, 3);
        add_idle();
        for (int n = 0; n < 6; n++) add_txn(1'b1, 1'b0, 4'hF, 4'h0, mix_own[n], 32'h2222_0000 + 32'(n), 0);
        add_idle();

        cpu_addr = CPU_ADDR; cpu_wdata = CPU_WD; cpu_sel = CPU_SEL;
        dma_addr  = {ch_addr(3), ch_addr(2), ch_addr(1), ch_addr(0)};
        dma_wdata = {ch_wd(3), ch_wd(2), ch_wd(1), ch_wd(0)};
        cpu_stb = 1'b0; cpu_we = 1'b0; dma_req = '0; dma_we = '0; mem_ack = 1'b0; mem_din = '0;
        reset_n = 1'b0;
        #50;
        chk("rst.gid", 32'(grant_id), 32'd7);
        chk("rst.strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("rst.acks", {27'd0, cpu_ack, dma_ack}, 32'd0);
        chk("rst.addr", mem_addr, 32'd0);
        chk("rst.sel", 32'(mem_sel), 32'd0);
        chk("rst.rdata", cpu_rdata | dma_rdata, 32'd0);
        chk("rst.flag", 32'(timeout_flag), 32'd0);
        @(negedge clk_25m);
        reset_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            cpu_stb = vt[i].cpu_stb; cpu_we = vt[i].cpu_we;
            dma_req = vt[i].dma_req; dma_we = vt[i].dma_we;
            mem_ack = vt[i].mem_ack; mem_din = vt[i].mem_din;
            tick();
            chk($sformatf("v%0d.gid", i), 32'(grant_id), 32'(vt[i].gid));
            chk($sformatf("v%0d.rd", i), 32'(mem_rd), 32'(vt[i].rd));
            chk($sformatf("v%0d.wr", i), 32'(mem_wr), 32'(vt[i].wr));
            chk($sformatf("v%0d.cack", i), 32'(cpu_ack), 32'(vt[i].cack));
            chk($sformatf("v%0d.dack", i), 32'(dma_ack), 32'(vt[i].dack));
            chk($sformatf("v%0d.addr", i), mem_addr, vt[i].addr);
            chk($sformatf("v%0d.dout", i), mem_dout, vt[i].dout);
            chk($sformatf("v%0d.sel", i), 32'(mem_sel), 32'(vt[i].sel));
            chk($sformatf("v%0d.crd", i), cpu_rdata, vt[i].crd);
            chk($sformatf("v%0d.drd", i), dma_rdata, vt[i].drd);
            chk($sformatf("v%0d.flag", i), 32'(timeout_flag), 32'd0);
        end

        // Reset asserted mid-ACCESS aborts without an ack, then a fresh request is served.
        cpu_stb = 1'b1; cpu_we = 1'b0; mem_ack = 1'b0;
        tick();
        chk("ra.rd_before", 32'(mem_rd), 32'd1);
        #5 reset_n = 1'b0;
        #1;
        chk("ra.strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("ra.acks", {27'd0, cpu_ack, dma_ack}, 32'd0);
        chk("ra.gid", 32'(grant_id), 32'd7);
        chk("ra.rdata", cpu_rdata | dma_rdata, 32'd0);
        @(negedge clk_25m);
        reset_n = 1'b1;
        tick();
        chk("ra.restart_rd", 32'(mem_rd), 32'd1);
        chk("ra.restart_gid", 32'(grant_id), 32'd0);
        mem_ack = 1'b1; mem_din = 32'h0BAD_CAFE;
        tick();
        cpu_done_check("ra.done", 32'h0BAD_CAFE, 1'b0);
        mem_ack = 1'b0;
        tick();
        cpu_stb = 1'b0;
        tick();
        chk("ra.idle_gid", 32'(grant_id), 32'd7);

`ifdef MEMARB_TIMEOUT_EN
        // mem_ack coinciding with the 8th ACCESS cycle completes normally.
        cpu_stb = 1'b1;
        tick();
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("tc.rd_c%0d", k), 32'(mem_rd), 32'd1);
        end
        mem_ack = 1'b1; mem_din = 32'h600D_600D;
        tick();
        cpu_done_check("tc.done", 32'h600D_600D, 1'b0);
        mem_ack = 1'b0;
        tick();
        cpu_stb = 1'b0;
        tick();
        // No mem_ack: eight ACCESS cycles then a poisoned ack and a sticky flag.
        cpu_stb = 1'b1;
        tick();
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("to.rd_c%0d", k), 32'(mem_rd), 32'd1);
        end
        tick();
        cpu_done_check("to.done", 32'hBAD0_BAD0, 1'b1);
        tick();
        mem_ack = 1'b1; mem_din = 32'h7777_0001;
        tick();
        chk("to.next_rd", 32'(mem_rd), 32'd1);
        tick();
        cpu_done_check("to.next", 32'h7777_0001, 1'b1);
        mem_ack = 1'b0;
        tick();
        cpu_stb = 1'b0;
        tick();
        chk("to.sticky", 32'(timeout_flag), 32'd1);
`else
        chk("flag.tied", 32'(timeout_flag), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
